// File: rtl/tlc_receiver.sv
// Receive side of the serial LED-driver link: shift/latch of GS and DC frames,
// with per-channel PWM generation. All link pins are oversampled on clock.
module tlc_receiver #(
  parameter int CHANNELS    = 16,
  parameter int GS_BITS     = 12,
  parameter int DC_BITS     = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          led_sclk,
  input  logic                          led_sin,
  input  logic                          led_mode,
  input  logic                          led_xlat,
  input  logic                          led_blank,
  input  logic                          led_gsclk,
  input  logic                          err_clr,
  input  logic [$clog2(CHANNELS)-1:0]   rd_sel,
  output logic                          led_sout,
  output logic [CHANNELS-1:0]           led_out,
  output logic [GS_BITS-1:0]            rd_gs,
  output logic [DC_BITS-1:0]            rd_dc,
  output logic                          xlat_pulse,
  output logic                          len_err
);

  localparam int GS_W = CHANNELS * GS_BITS;
  localparam int DC_W = CHANNELS * DC_BITS;
  localparam logic [9:0] GS_LEN = 10'(GS_W);
  localparam logic [9:0] DC_LEN = 10'(DC_W);
  localparam logic [GS_BITS-1:0] PWM_MAX = '1;

  // sync bit order {gsclk, blank, xlat, mode, sin, sclk}; blank idles high
  localparam logic [5:0] SYNC_RST = 6'b010000;

  logic [5:0]            sync_q [SYNC_STAGES];
  logic [2:0]            edge_q;
  logic [GS_W-1:0]       shift_q, shift_d;
  logic [9:0]            cnt_q, cnt_d;
  logic [GS_BITS-1:0]    gs_q [CHANNELS];
  logic [DC_BITS-1:0]    dc_q [CHANNELS];
  logic [GS_BITS-1:0]    pwm_q;
  logic [CHANNELS-1:0]   out_q;
  logic                  pulse_q;
  logic                  err_q;

  logic sclk_s, sin_s, mode_s, xlat_s, blank_s, gsclk_s;
  logic sclk_rise, xlat_rise, gsclk_rise;
  logic bad_len;

  assign {gsclk_s, blank_s, xlat_s, mode_s, sin_s, sclk_s} = sync_q[SYNC_STAGES-1];

  assign sclk_rise  = sclk_s  & ~edge_q[0];
  assign xlat_rise  = xlat_s  & ~edge_q[1];
  assign gsclk_rise = gsclk_s & ~edge_q[2];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= SYNC_RST;
      edge_q <= '0;
    end else begin
      sync_q[0] <= {led_gsclk, led_blank, led_xlat,
                    led_mode, led_sin, led_sclk};
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      edge_q <= {gsclk_s, xlat_s, sclk_s};
    end
  end

  // the latch sees the post-shift view when sclk and xlat coincide
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (sclk_rise) begin
      shift_d = {shift_q[GS_W-2:0], sin_s};
      if (cnt_q != 10'h3FF) cnt_d = cnt_q + 10'd1;
    end
  end

  assign bad_len = mode_s ? (cnt_d != DC_LEN) : (cnt_d != GS_LEN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        gs_q[i] <= '0;
        dc_q[i] <= '0;
      end
    end else begin
      shift_q <= shift_d;
      cnt_q   <= xlat_rise ? 10'd0 : cnt_d;
      pulse_q <= xlat_rise;
      if (xlat_rise && bad_len) err_q <= 1'b1;
      else if (err_clr)         err_q <= 1'b0;
      if (xlat_rise) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (mode_s) dc_q[i] <= shift_d[i*DC_BITS +: DC_BITS];
          else        gs_q[i] <= shift_d[i*GS_BITS +: GS_BITS];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pwm_q <= '0;
      out_q <= '0;
    end else begin
      if (blank_s)
        pwm_q <= '0;
      else if (gsclk_rise && pwm_q != PWM_MAX)
        pwm_q <= pwm_q + 1'b1;
      for (int i = 0; i < CHANNELS; i++)
        out_q[i] <= !blank_s && (pwm_q < gs_q[i]);
    end
  end

  always_comb begin
    rd_gs = '0;
    rd_dc = '0;
    if (int'(rd_sel) < CHANNELS) begin
      rd_gs = gs_q[rd_sel];
      rd_dc = dc_q[rd_sel];
    end
  end

  assign led_sout   = shift_q[GS_W-1];
  assign led_out    = out_q;
  assign xlat_pulse = pulse_q;
  assign len_err    = err_q;

endmodule

// File: tb/tb_tlc_receiver.sv
// Directed bench for tlc_receiver: frame latching, length errors,
// PWM counts, saturation, coincident edges and mid-frame reset.
module tb_tlc_receiver;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        led_sclk, led_sin, led_mode, led_xlat;
  logic        led_blank, led_gsclk, err_clr;
  logic [3:0]  rd_sel;
  logic        led_sout;
  logic [15:0] led_out;
  logic [11:0] rd_gs;
  logic [5:0]  rd_dc;
  logic        xlat_pulse;
  logic        len_err;

  int checks = 0;
  int errors = 0;
  int on_cnt;

  tlc_receiver dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .led_sclk   (led_sclk),
    .led_sin    (led_sin),
    .led_mode   (led_mode),
    .led_xlat   (led_xlat),
    .led_blank  (led_blank),
    .led_gsclk  (led_gsclk),
    .err_clr    (err_clr),
    .rd_sel     (rd_sel),
    .led_sout   (led_sout),
    .led_out    (led_out),
    .rd_gs      (rd_gs),
    .rd_dc      (rd_dc),
    .xlat_pulse (xlat_pulse),
    .len_err    (len_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold3();
    repeat (3) @(negedge clock);
  endtask

  task automatic send_bit(input logic b);
    led_sin  = b;
    hold3();
    led_sclk = 1'b1;
    hold3();
    led_sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [191:0] f, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(f[i]);
    hold3();
  endtask

  task automatic latch(input logic mode, input string tag);
    bit seen;
    seen = 1'b0;
    led_mode = mode;
    hold3();
    led_xlat = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (xlat_pulse) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_pulse"}, 32'(seen), 32'd1);
    @(negedge clock);
    chk({tag, "_pulse1clk"}, 32'(xlat_pulse), 32'd0);
    led_xlat = 1'b0;
    hold3();
  endtask

  task automatic rd(input logic [3:0] ch);
    rd_sel = ch;
    #1;
  endtask

  task automatic pwm_run(input int n, input int ch, output int on);
    on = 0;
    for (int k = 0; k < n; k++) begin
      if (led_out[ch]) on++;
      led_gsclk = 1'b1;
      hold3();
      led_gsclk = 1'b0;
      hold3();
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    led_sclk  = 1'b0;
    led_sin   = 1'b0;
    led_mode  = 1'b0;
    led_xlat  = 1'b0;
    led_blank = 1'b1;
    led_gsclk = 1'b0;
    err_clr   = 1'b0;
    rd_sel    = 4'd0;
    repeat (4) @(negedge clock);
    reset_n = 1'b1;
    hold3();

    chk("rst_out",   32'(led_out), 32'h0);
    chk("rst_sout",  32'(led_sout), 32'h0);
    chk("rst_err",   32'(len_err), 32'h0);
    chk("rst_pulse", 32'(xlat_pulse), 32'h0);
    rd(4'd0);
    chk("rst_gs",    32'(rd_gs), 32'h0);

    // DC frame
    send_bits({96'h0, {16{6'b000001}}}, 96);
    latch(1'b1, "dc");
    rd(4'd0);  chk("dc_ch0",  32'(rd_dc), 32'h1);
    rd(4'd7);  chk("dc_ch7",  32'(rd_dc), 32'h1);
    rd(4'd15); chk("dc_ch15", 32'(rd_dc), 32'h1);
    chk("dc_err", 32'(len_err), 32'h0);

    // GS frame and PWM
    send_bits({12'h0FF, 12'h0FF, {14{12'h000}}}, 192);
    latch(1'b0, "gs");
    rd(4'd15); chk("gs_ch15", 32'(rd_gs), 32'h0FF);
    rd(4'd14); chk("gs_ch14", 32'(rd_gs), 32'h0FF);
    rd(4'd0);  chk("gs_ch0",  32'(rd_gs), 32'h000);
    rd(4'd15); chk("gs_dc_kept", 32'(rd_dc), 32'h1);
    chk("gs_err", 32'(len_err), 32'h0);
    chk("blank_off", 32'(led_out), 32'h0);
    led_blank = 1'b0;
    repeat (6) @(negedge clock);
    pwm_run(300, 15, on_cnt);
    chk("pwm255_on", 32'(on_cnt), 32'd255);
    chk("pwm255_end", 32'(led_out[15]), 32'h0);
    led_blank = 1'b1;
    repeat (6) @(negedge clock);
    chk("reblank_out", 32'(led_out), 32'h0);

    // short frame
    send_bits(192'h0, 191);
    latch(1'b0, "short");
    chk("short_err", 32'(len_err), 32'h1);
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    chk("errclr", 32'(len_err), 32'h0);
    send_bits({12'hABC, {14{12'h000}}, 12'h123}, 192);
    latch(1'b0, "full");
    chk("full_err", 32'(len_err), 32'h0);
    rd(4'd15); chk("full_ch15", 32'(rd_gs), 32'hABC);
    rd(4'd0);  chk("full_ch0",  32'(rd_gs), 32'h123);
    chk("full_sout", 32'(led_sout), 32'h1);

    // saturation
    send_bits({12'h800, {14{12'h000}}, 12'hFFF}, 192);
    latch(1'b0, "sat");
    rd(4'd0);  chk("sat_ch0",  32'(rd_gs), 32'hFFF);
    rd(4'd15); chk("sat_ch15", 32'(rd_gs), 32'h800);
    chk("sat_sout", 32'(led_sout), 32'h1);
    led_blank = 1'b0;
    repeat (6) @(negedge clock);
    pwm_run(5000, 0, on_cnt);
    chk("sat_on", 32'(on_cnt), 32'd4095);
    chk("sat_end", 32'(led_out[0]), 32'h0);
    led_blank = 1'b1;
    repeat (6) @(negedge clock);

    // coincident sclk/xlat on bit 192
    send_bits({12'h000, {14{12'h000}}, 12'h001} >> 1, 191);
    led_mode = 1'b0;
    led_sin  = 1'b1;
    hold3();
    led_sclk = 1'b1;
    led_xlat = 1'b1;
    hold3();
    led_sclk = 1'b0;
    led_xlat = 1'b0;
    repeat (4) @(negedge clock);
    chk("sim_err", 32'(len_err), 32'h0);
    rd(4'd0); chk("sim_ch0", 32'(rd_gs), 32'h001);

    // reset mid-frame
    send_bits({192{1'b1}}, 100);
    reset_n = 1'b0;
    @(negedge clock);
    chk("mid_out",   32'(led_out), 32'h0);
    chk("mid_sout",  32'(led_sout), 32'h0);
    chk("mid_err",   32'(len_err), 32'h0);
    rd(4'd0); chk("mid_gs", 32'(rd_gs), 32'h0);
    reset_n = 1'b1;
    hold3();
    send_bits({12'h000, {14{12'h000}}, 12'h5A5}, 192);
    latch(1'b0, "post");
    chk("post_err", 32'(len_err), 32'h0);
    rd(4'd0); chk("post_ch0", 32'(rd_gs), 32'h5A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
